muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the EX stage. It takes MULT, MULTU, DIV and DIVU operations issued from EX, runs an iterative shift-add multiplier or restoring divider over its own registered state, and stalls the pipeline while busy. On completion it pulses a one-cycle HI/LO write carrying the 64-bit result into the HI/LO register file.

## Interface
Parameters:
- none (latency selected by macro, see Configuration)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous reset, active-low (rst=0 resets on clk rising edge)
- start  in  1  one-cycle issue pulse from ID/EX; qualifies funct/operands
- funct  in  6  `FUNCT_MULT / `FUNCT_MULTU / `FUNCT_DIV / `FUNCT_DIVU; any other value with start=1 is ignored
- operand_1  in  32  multiplicand / dividend (rs)
- operand_2  in  32  multiplier / divisor (rt)
- flush  in  1  cancel current operation, no HI/LO write
- stall_req  out  1  pipeline stall request
- hilo_write_en  out  1  one-cycle HI/LO write strobe
- hi_out  out  32  product[63:32] / remainder
- lo_out  out  32  product[31:0] / quotient

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE: start=1 with a valid funct latches |operand_1|, |operand_2| (absolute value for MULT/DIV, raw for MULTU/DIVU), result-sign flags and op type; counter←0; next MUL or DIV.
- MUL: per cycle, if multiplier LSB=1, add multiplicand to the upper half of a 64-bit accumulator; shift right 1. After 32 iterations (counter==31) → DONE.
- DIV: restoring; 64-bit {rem,quo} shifted left 1 per cycle, trial subtract divisor from the upper 33 bits, set quotient bit on non-negative. 32 iterations → DONE.
- DONE: sign fix-up, register hi_out/lo_out, hilo_write_en=1 for exactly this cycle, next IDLE.
- Sign rules: MULT product negated if sign(op1)^sign(op2). DIV quotient negated if sign(op1)^sign(op2); remainder takes sign of op1. 0x80000000 / -1 (DIV) → lo=0x80000000, hi=0.
- Divide by zero (either DIV or DIVU): full iteration count still runs; result forced to lo=0xFFFFFFFF, hi=operand_1 (original, unsigned form).
- start while not IDLE: ignored (pipeline guarantees it cannot happen; no queuing).
- stall_req = (state==IDLE && start && valid funct && !flush) || state==MUL || state==DIV. Low in DONE, so EX advances in the same cycle HI/LO is written.
- flush: any state → IDLE next edge; hilo_write_en forced 0 in that cycle; flush with start in IDLE: start ignored. flush in DONE suppresses the write.
- hi_out/lo_out hold last written value between operations.

## Timing
- Reset (rst=0 at edge): state IDLE, counter 0, stall_req 0 (combinational term gated by rst=0 as well), hilo_write_en 0, hi_out 0, lo_out 0. Reset mid-operation abandons it with no write.
- Start accepted in cycle T: stall_req high from T combinationally.
- Iterative: iterations T+1..T+32, DONE at T+33: hilo_write_en=1, stall_req=0, hi/lo valid in T+33.
- New start accepted earliest T+34 (IDLE).
- All state changes on clk rising edge; only stall_req has a combinational path (from start/funct/flush).

## Configuration
- MUL_FAST_MULT_EN defined: MULT/MULTU compute the full 64-bit product (signed/unsigned `*`) in one MUL cycle; DONE at T+2, stall_req high for T and T+1 only. DIV timing unchanged.
- Undefined: MULT/MULTU use the 32-iteration shift-add path; DONE at T+33.

## Test plan
- MULT op1=0xFFFFFFFD (-3), op2=7, start at T -> stall_req high T..T+32, at T+33 hilo_write_en=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB (T+2 with MUL_FAST_MULT_EN).
- DIVU 100/7 -> at T+33 lo=14, hi=2; DIV 0xFFFFFFF9 (-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; back-to-back start at T+34 with new operands -> second result at T+67, first outputs held in between.
- flush at T+10 of a DIV -> state IDLE at T+11, stall_req 0 from T+11, no hilo_write_en pulse; hi/lo unchanged.
- rst=0 at T+20 of a MULT -> all outputs 0 next cycle, no write; start with funct=`FUNCT_ADD -> stall_req stays 0, no write.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Issue/result bundle between the EX stage and the multiply/divide sequencer.
// Master is the EX side; slave is the sequencer.
interface muldiv_ctrl_if;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        stall_req;
    logic        hilo_write_en;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output start, funct, operand_1, operand_2, flush,
        input  stall_req, hilo_write_en, hi_out, lo_out
    );

    modport slave (
        input  start, funct, operand_1, operand_2, flush,
        output stall_req, hilo_write_en, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with a one-cycle HI/LO write on completion.
// Define MUL_FAST_MULT_EN for single-cycle multiplies (divides stay 32 iterations).
`ifndef FUNCT_MULT
`define FUNCT_MULT  6'b011000
`endif
`ifndef FUNCT_MULTU
`define FUNCT_MULTU 6'b011001
`endif
`ifndef FUNCT_DIV
`define FUNCT_DIV   6'b011010
`endif
`ifndef FUNCT_DIVU
`define FUNCT_DIVU  6'b011011
`endif

module muldiv_ctrl (
    input logic           clk,
    input logic           rst,
    muldiv_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opa_q, opa_d;      // multiplicand for MUL, divisor for DIV
    logic [31:0] op1_q, op1_d;
    logic        neg_q, neg_d, rem_neg_q, rem_neg_d;
    logic        div_zero_q, div_zero_d, is_div_q, is_div_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        valid_funct, is_signed, is_div, stall, write;
    logic [31:0] abs_1, abs_2, fix_hi, fix_lo;
    logic [63:0] prod_fix;
    logic [32:0] div_top;
    logic [31:0] div_rem;
    logic        div_ge;

    assign valid_funct = (bus.funct == `FUNCT_MULT) || (bus.funct == `FUNCT_MULTU) ||
                         (bus.funct == `FUNCT_DIV)  || (bus.funct == `FUNCT_DIVU);
    assign is_signed   = (bus.funct == `FUNCT_MULT) || (bus.funct == `FUNCT_DIV);
    assign is_div      = (bus.funct == `FUNCT_DIV)  || (bus.funct == `FUNCT_DIVU);
    assign abs_1 = (is_signed && bus.operand_1[31]) ? -bus.operand_1 : bus.operand_1;
    assign abs_2 = (is_signed && bus.operand_2[31]) ? -bus.operand_2 : bus.operand_2;

    // Trial subtract on the shifted upper 33 bits; a true remainder always fits in 32.
    assign div_top = acc_q[63:31];
    assign div_ge  = div_top >= {1'b0, opa_q};
    assign div_rem = div_top[31:0] - opa_q;

`ifndef MUL_FAST_MULT_EN
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, opa_q};
`endif

    assign prod_fix = neg_q ? -acc_q : acc_q;

    always_comb begin
        fix_hi = prod_fix[63:32];
        fix_lo = prod_fix[31:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                fix_hi = op1_q;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = rem_neg_q ? -acc_q[63:32] : acc_q[63:32];
                fix_lo = neg_q ? -acc_q[31:0] : acc_q[31:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opa_d      = opa_q;
        op1_d      = op1_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        is_div_d   = is_div_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        stall      = 1'b0;
        write      = 1'b0;
        unique case (state_q)
            StIdle: begin
                stall = bus.start && valid_funct && !bus.flush;
                if (stall) begin
                    cnt_d      = '0;
                    is_div_d   = is_div;
                    op1_d      = bus.operand_1;
                    neg_d      = is_signed && (bus.operand_1[31] ^ bus.operand_2[31]);
                    rem_neg_d  = is_signed && bus.operand_1[31];
                    div_zero_d = is_div && (bus.operand_2 == 32'd0);
                    opa_d      = is_div ? abs_2 : abs_1;
                    acc_d      = {32'd0, is_div ? abs_1 : abs_2};
                    state_d    = is_div ? StDiv : StMul;
                end
            end
            StMul: begin
                stall = 1'b1;
`ifdef MUL_FAST_MULT_EN
                acc_d   = 64'(opa_q) * 64'(acc_q[31:0]);
                state_d = StDone;
`else
                acc_d = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = StDone;
`endif
            end
            StDiv: begin
                stall = 1'b1;
                acc_d = div_ge ? {div_rem, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = StDone;
            end
            StDone: begin
                write   = !bus.flush;
                state_d = StIdle;
                if (!bus.flush) begin
                    hi_d = fix_hi;
                    lo_d = fix_lo;
                end
            end
            default: state_d = StIdle;
        endcase
        if (bus.flush) state_d = StIdle;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            opa_q      <= '0;
            op1_q      <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            is_div_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opa_q      <= opa_d;
            op1_q      <= op1_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            is_div_q   <= is_div_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // The result is presented during DONE itself so HI/LO sees it with the write strobe.
    assign bus.stall_req     = rst && stall;
    assign bus.hilo_write_en = rst && write;
    assign bus.hi_out        = (state_q == StDone) ? fix_hi : hi_q;
    assign bus.lo_out        = (state_q == StDone) ? fix_lo : lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: signed/unsigned mul/div, corner cases, flush, reset, bad funct.
module tb_muldiv_ctrl;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
`ifdef MUL_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait (bounded) for the write strobe, and check latency, stall and hold.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_lat);
        logic [31:0] prev_hi, prev_lo;
        int lat;
        bit stall_ok, hold_ok, seen;
        prev_hi = bus.hi_out;
        prev_lo = bus.lo_out;
        lat = 0;
        stall_ok = 1'b1;
        hold_ok = 1'b1;
        seen = 1'b0;
        bus.start = 1'b1;
        bus.funct = f;
        bus.operand_1 = a;
        bus.operand_2 = b;
        #1;
        check({tag, " stall_at_issue"}, 32'(bus.stall_req), 32'd1);
        for (int n = 1; n <= 40 && !seen; n++) begin
            tick();
            bus.start = 1'b0;
            if (bus.hilo_write_en) begin
                seen = 1'b1;
                lat = n;
            end else begin
                if (bus.stall_req !== 1'b1) stall_ok = 1'b0;
                if (bus.hi_out !== prev_hi || bus.lo_out !== prev_lo) hold_ok = 1'b0;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " stall_while_busy"}, 32'(stall_ok), 32'd1);
        check({tag, " outputs_held"}, 32'(hold_ok), 32'd1);
        check({tag, " stall_in_done"}, 32'(bus.stall_req), 32'd0);
        check({tag, " hi"}, bus.hi_out, exp_hi);
        check({tag, " lo"}, bus.lo_out, exp_lo);
        tick();
        check({tag, " write_after_done"}, 32'(bus.hilo_write_en), 32'd0);
        check({tag, " hi_held"}, bus.hi_out, exp_hi);
        check({tag, " lo_held"}, bus.lo_out, exp_lo);
    endtask

    initial begin
        int writes;
        bus.start = 1'b0;
        bus.funct = '0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.flush = 1'b0;

        tick();
        tick();
        check("reset stall", 32'(bus.stall_req), 32'd0);
        check("reset write", 32'(bus.hilo_write_en), 32'd0);
        check("reset hi", bus.hi_out, 32'd0);
        check("reset lo", bus.lo_out, 32'd0);
        rst = 1'b1;
        tick();

        run_op("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
        run_op("div_neg7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT);
        run_op("divu_5_0", F_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_LAT);
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
               MUL_LAT);
        // Back-to-back: issued in the cycle right after the previous op returned to idle.
        run_op("mult_b2b", F_MULT, 32'h0000_1234, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_DB98,
               MUL_LAT);

        // Flush at T+10 of a divide.
        bus.start = 1'b1;
        bus.funct = F_DIVU;
        bus.operand_1 = 32'd1000;
        bus.operand_2 = 32'd3;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        check("flush stall", 32'(bus.stall_req), 32'd0);
        check("flush write", 32'(bus.hilo_write_en), 32'd0);
        check("flush hi", bus.hi_out, 32'hFFFF_FFFF);
        check("flush lo", bus.lo_out, 32'hFFFF_DB98);
        writes = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.hilo_write_en) writes++;
        end
        check("flush no_write", 32'(writes), 32'd0);

        // Reset at T+20 of a multiply.
        bus.start = 1'b1;
        bus.funct = F_MULT;
        bus.operand_1 = 32'd5;
        bus.operand_2 = 32'd6;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        rst = 1'b0;
        tick();
        check("rst_mid hi", bus.hi_out, 32'd0);
        check("rst_mid lo", bus.lo_out, 32'd0);
        check("rst_mid write", 32'(bus.hilo_write_en), 32'd0);
        check("rst_mid stall", 32'(bus.stall_req), 32'd0);
        rst = 1'b1;
        writes = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.hilo_write_en) writes++;
        end
        check("rst_mid no_write", 32'(writes), 32'd0);

        // Non-muldiv funct is ignored.
        bus.start = 1'b1;
        bus.funct = F_ADD;
        #1;
        check("bad_funct stall", 32'(bus.stall_req), 32'd0);
        tick();
        bus.start = 1'b0;
        writes = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (bus.hilo_write_en || bus.stall_req) writes++;
        end
        check("bad_funct idle", 32'(writes), 32'd0);

        // Start coinciding with flush in idle is dropped.
        bus.start = 1'b1;
        bus.funct = F_DIV;
        bus.operand_1 = 32'd9;
        bus.operand_2 = 32'd3;
        bus.flush = 1'b1;
        #1;
        check("flush_start stall", 32'(bus.stall_req), 32'd0);
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1;
        check("flush_start idle", 32'(bus.stall_req), 32'd0);
        writes = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.hilo_write_en) writes++;
        end
        check("flush_start no_write", 32'(writes), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
